card_sprite_reader: RTL and testbench

- Read-side client of the 512x3 card image RAM: 16-pixel-wide x 32-row card sprite, 3-bit colour per pixel.
- Takes the VGA pixel stream coordinates (256x240 resolution) and issues card RAM reads when the current pixel falls inside the card rectangle.
- Merges the returned RAM data over a background colour and sends the pixel colour to the VGA output stage.
- Card position and mirror setting are double-buffered and update only at frame start, so the card never tears.

---
 rtl/card_sprite_reader_if.sv | 20 ++
 rtl/card_sprite_reader.sv | 149 ++++++++++++++
 tb/tb_card_sprite_reader.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/card_sprite_reader_if.sv
`default_nettype none
// ============================================================================
//  Module      : card_sprite_reader_if
//  Description : Read port of the 512x3 card image RAM.
//                master : sprite reader (drives RE/rAddr, receives dataOut)
//                slave  : RAM side      (receives RE/rAddr, drives dataOut)
//  Signals     : RE      - read enable
//                rAddr   - 9-bit read address {row[4:0], col[3:0]}
//                dataOut - 3-bit colour, valid one clock after RE/rAddr
//  Revision    : 1.0  initial release
// ============================================================================
interface card_sprite_reader_if;
    logic       RE;
    logic [8:0] rAddr;
    logic [2:0] dataOut;

    modport master (output RE, output rAddr, input dataOut);
    modport slave  (input RE, input rAddr, output dataOut);
endinterface
`default_nettype wire

// File: rtl/card_sprite_reader.sv
`default_nettype none
// ============================================================================
//  Module      : card_sprite_reader
//  Description : Overlays a 16x32 card sprite, read from the card image RAM,
//                on a background colour for a 256x240 VGA pixel stream.
//                Card position/enable/mirror are latched at frame start so
//                the card never tears. Fixed 2-clock latency, 1 pixel/clock.
//  Ports       : clock, reset          - clock, synchronous active-high reset
//                pixel_valid/x/y       - current pixel of the video stream
//                card_x/y, card_en,
//                mirror_h              - shadow card settings
//                bg_color              - background colour
//                ram (master)          - RE/rAddr out, dataOut in
//                color_out/color_valid - final pixel colour and its qualifier
//                in_card               - output pixel lies inside the card
//  Revision    : 1.0  initial release
// ============================================================================
module card_sprite_reader #(
    parameter int         CARD_W      = 16,
    parameter int         CARD_H      = 32,
    parameter logic [2:0] TRANSPARENT = 3'b000
) (
    input  wire logic        clock,
    input  wire logic        reset,
    input  wire logic        pixel_valid,
    input  wire logic [7:0]  pixel_x,
    input  wire logic [7:0]  pixel_y,
    input  wire logic [7:0]  card_x,
    input  wire logic [7:0]  card_y,
    input  wire logic        card_en,
    input  wire logic        mirror_h,
    input  wire logic [2:0]  bg_color,
    card_sprite_reader_if.master ram,
    output logic [2:0]       color_out,
    output logic             color_valid,
    output logic             in_card
);

    localparam int c_COL_W = $clog2(CARD_W);
    localparam int c_ROW_W = $clog2(CARD_H);
    localparam logic [c_COL_W-1:0] c_COL_MAX = c_COL_W'(CARD_W - 1);
    localparam logic [8:0]         c_W9      = 9'(CARD_W);
    localparam logic [8:0]         c_H9      = 9'(CARD_H);

    // Active (frame-latched) card settings
    logic [7:0] r_act_x;
    logic [7:0] r_act_y;
    logic       r_act_en;
    logic       r_act_mirror;

    // Stage-0 outputs / stage-1 pipeline
    logic       r_re;
    logic [8:0] r_addr;
    logic       r_v1;
    logic       r_hit1;
    logic [2:0] r_bg1;

    logic               w_frame_start;
    logic [7:0]         w_eff_x;
    logic [7:0]         w_eff_y;
    logic               w_eff_en;
    logic               w_eff_mirror;
    logic [8:0]         w_dx;
    logic [8:0]         w_dy;
    logic               w_hit;
    logic [c_COL_W-1:0] w_col;
    logic [c_ROW_W-1:0] w_row;
    logic [8:0]         w_addr;

    assign w_frame_start = pixel_valid && (pixel_x == 8'd0) && (pixel_y == 8'd0);

    // The (0,0) pixel itself already uses the newly latched settings, so a
    // card placed at the origin is drawn correctly from its very first pixel.
    assign w_eff_x      = w_frame_start ? card_x   : r_act_x;
    assign w_eff_y      = w_frame_start ? card_y   : r_act_y;
    assign w_eff_en     = w_frame_start ? card_en  : r_act_en;
    assign w_eff_mirror = w_frame_start ? mirror_h : r_act_mirror;

    // 9-bit differences: a pixel left of/above the card yields a large value,
    // so the card is clipped at the screen edge rather than wrapped.
    assign w_dx = {1'b0, pixel_x} - {1'b0, w_eff_x};
    assign w_dy = {1'b0, pixel_y} - {1'b0, w_eff_y};

    assign w_hit = pixel_valid && w_eff_en
                && (pixel_x >= w_eff_x) && (w_dx < c_W9)
                && (pixel_y >= w_eff_y) && (w_dy < c_H9);

    assign w_col  = w_eff_mirror ? (c_COL_MAX - w_dx[c_COL_W-1:0]) : w_dx[c_COL_W-1:0];
    assign w_row  = w_dy[c_ROW_W-1:0];
    assign w_addr = {w_row, w_col};

    // Frame-start latch of the shadow settings
    always_ff @(posedge clock) begin
        if (reset) begin
            r_act_x      <= 8'd0;
            r_act_y      <= 8'd0;
            r_act_en     <= 1'b0;
            r_act_mirror <= 1'b0;
        end else if (w_frame_start) begin
            r_act_x      <= card_x;
            r_act_y      <= card_y;
            r_act_en     <= card_en;
            r_act_mirror <= mirror_h;
        end
    end

    // Stage 0 -> RAM request and stage-1 pipeline
    always_ff @(posedge clock) begin
        if (reset) begin
            r_re   <= 1'b0;
            r_addr <= 9'd0;
            r_v1   <= 1'b0;
            r_hit1 <= 1'b0;
            r_bg1  <= 3'd0;
        end else begin
            r_re   <= w_hit;
            if (w_hit) begin
                r_addr <= w_addr;
            end
            r_v1   <= pixel_valid;
            r_hit1 <= w_hit;
            r_bg1  <= bg_color;
        end
    end

    // Output stage: captures the RAM word on the clock after the request
    always_ff @(posedge clock) begin
        if (reset) begin
            color_out   <= 3'd0;
            color_valid <= 1'b0;
            in_card     <= 1'b0;
        end else begin
            color_valid <= r_v1;
            in_card     <= r_v1 && r_hit1;
            if (!r_v1) begin
                color_out <= 3'd0;
            end else if (r_hit1 && (ram.dataOut != TRANSPARENT)) begin
                color_out <= ram.dataOut;
            end else begin
                color_out <= r_bg1;
            end
        end
    end

    assign ram.RE    = r_re;
    assign ram.rAddr = r_addr;

endmodule
`default_nettype wire

// File: tb/tb_card_sprite_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_card_sprite_reader
//  Description : Directed self-checking bench for card_sprite_reader with a
//                behavioural card RAM (data valid in the clock after rAddr).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_card_sprite_reader;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       pixel_valid = 1'b0;
    logic [7:0] pixel_x = 8'd0;
    logic [7:0] pixel_y = 8'd0;
    logic [7:0] card_x = 8'd0;
    logic [7:0] card_y = 8'd0;
    logic       card_en = 1'b0;
    logic       mirror_h = 1'b0;
    logic [2:0] bg_color = 3'd0;
    logic [2:0] color_out;
    logic       color_valid;
    logic       in_card;

    logic [2:0] mem [512];

    int n_cmp = 0;
    int n_err = 0;

    card_sprite_reader_if ram_if ();

    assign ram_if.dataOut = mem[ram_if.rAddr];

    card_sprite_reader dut (
        .clock       (clock),
        .reset       (reset),
        .pixel_valid (pixel_valid),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .card_x      (card_x),
        .card_y      (card_y),
        .card_en     (card_en),
        .mirror_h    (mirror_h),
        .bg_color    (bg_color),
        .ram         (ram_if),
        .color_out   (color_out),
        .color_valid (color_valid),
        .in_card     (in_card)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present one pixel, then advance one clock
    task automatic pix(input logic v, input logic [7:0] x, input logic [7:0] y);
        pixel_valid = v;
        pixel_x     = x;
        pixel_y     = y;
        tick();
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 3'd0;
        mem[0]   = 3'b101;
        mem[511] = 3'b011;
        bg_color = 3'b010;

        // Reset with a running pixel stream
        reset = 1'b1;
        pix(1'b1, 8'd10, 8'd20);
        pix(1'b1, 8'd11, 8'd20);
        chk("rst_RE",      ram_if.RE,    0);
        chk("rst_rAddr",   ram_if.rAddr, 0);
        chk("rst_cvalid",  color_valid,  0);
        chk("rst_color",   color_out,    0);
        chk("rst_incard",  in_card,      0);

        // Release reset; active enable is cleared, so no hit before frame start
        reset = 1'b0;
        pix(1'b1, 8'd10, 8'd20);
        chk("post_rst_RE",     ram_if.RE,   0);
        chk("post_rst_cvalid", color_valid, 0);

        // Frame start latches card at (10,20)
        card_x = 8'd10; card_y = 8'd20; card_en = 1'b1; mirror_h = 1'b0;
        pix(1'b1, 8'd0, 8'd0);
        chk("first_cvalid", color_valid, 1);
        chk("first_color",  color_out,   3'b010);
        chk("fs_RE",        ram_if.RE,   0);

        pix(1'b1, 8'd10, 8'd20);
        chk("p10_20_RE",    ram_if.RE,    1);
        chk("p10_20_addr",  ram_if.rAddr, 0);
        pix(1'b1, 8'd25, 8'd51);
        chk("p10_20_color", color_out,    3'b101);
        chk("p10_20_in",    in_card,      1);
        chk("p25_51_RE",    ram_if.RE,    1);
        chk("p25_51_addr",  ram_if.rAddr, 511);
        pix(1'b1, 8'd26, 8'd20);
        chk("p25_51_color", color_out,    3'b011);
        chk("p26_20_RE",    ram_if.RE,    0);
        chk("p26_20_hold",  ram_if.rAddr, 511);
        pix(1'b1, 8'd9, 8'd20);
        chk("p26_20_color", color_out,    3'b010);
        chk("p26_20_in",    in_card,      0);
        chk("p9_20_RE",     ram_if.RE,    0);
        pix(1'b0, 8'd0, 8'd0);
        chk("p9_20_color",  color_out,    3'b010);
        chk("p9_20_cvalid", color_valid,  1);
        chk("blank_RE",     ram_if.RE,    0);
        pix(1'b0, 8'd0, 8'd0);
        chk("blank_cvalid", color_valid,  0);
        chk("blank_color",  color_out,    0);

        // Transparent RAM word shows background but still reports in_card
        mem[0] = 3'b000;
        pix(1'b1, 8'd10, 8'd20);
        pix(1'b0, 8'd0, 8'd0);
        chk("transp_color", color_out, 3'b010);
        chk("transp_in",    in_card,   1);

        // Mid-frame shadow change is ignored until the next (0,0)
        mem[0] = 3'b101;
        card_x = 8'd50;
        pix(1'b1, 8'd100, 8'd100);
        pix(1'b1, 8'd10, 8'd20);
        chk("mid_old_RE",   ram_if.RE,    1);
        chk("mid_old_addr", ram_if.rAddr, 0);
        pix(1'b1, 8'd50, 8'd20);
        chk("mid_new_noRE", ram_if.RE,    0);
        pix(1'b1, 8'd0, 8'd0);
        pix(1'b1, 8'd50, 8'd20);
        chk("fs_new_RE",    ram_if.RE,    1);
        chk("fs_new_addr",  ram_if.rAddr, 0);
        pix(1'b1, 8'd10, 8'd20);
        chk("fs_old_noRE",  ram_if.RE,    0);

        // Mirror, card at the origin
        card_x = 8'd0; card_y = 8'd0; mirror_h = 1'b1;
        pix(1'b1, 8'd0, 8'd0);
        chk("mir_0_0_RE",   ram_if.RE,    1);
        chk("mir_0_0_addr", ram_if.rAddr, 15);
        pix(1'b1, 8'd15, 8'd1);
        chk("mir_15_1_addr", ram_if.rAddr, 16);

        // Card disabled: no reads, background passes through
        card_en = 1'b0; mirror_h = 1'b0; bg_color = 3'b110;
        pix(1'b1, 8'd0, 8'd0);
        chk("dis_RE", ram_if.RE, 0);
        pix(1'b1, 8'd5, 8'd5);
        chk("dis_RE2", ram_if.RE, 0);
        chk("dis_color", color_out, 3'b110);
        chk("dis_in",    in_card,   0);

        // Card near the bottom-right corner is clipped, not wrapped
        card_x = 8'd250; card_y = 8'd230; card_en = 1'b1; bg_color = 3'b010;
        pix(1'b1, 8'd0, 8'd0);
        chk("clip_fs_RE", ram_if.RE, 0);
        pix(1'b1, 8'd255, 8'd239);
        chk("clip_RE",    ram_if.RE,    1);
        chk("clip_addr",  ram_if.rAddr, 149);
        pix(1'b1, 8'd0, 8'd239);
        chk("nowrap_RE",  ram_if.RE,    0);
        chk("nowrap_hold", ram_if.rAddr, 149);

        // Reset mid-line discards in-flight data
        pix(1'b1, 8'd250, 8'd230);
        chk("preRst_RE", ram_if.RE, 1);
        reset = 1'b1;
        pix(1'b1, 8'd251, 8'd230);
        chk("midrst_RE",     ram_if.RE,    0);
        chk("midrst_addr",   ram_if.rAddr, 0);
        chk("midrst_cvalid", color_valid,  0);
        chk("midrst_color",  color_out,    0);
        reset = 1'b0;
        pix(1'b1, 8'd252, 8'd230);
        chk("rel_cvalid0", color_valid, 0);
        chk("rel_RE",      ram_if.RE,   0);
        pix(1'b1, 8'd253, 8'd230);
        chk("rel_cvalid1", color_valid, 1);
        chk("rel_color",   color_out,   3'b010);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
